// File: rtl/pkt_timer_ring.sv
// pkt_timer_ring: timing ring of header records with per-slot countdown timers.
// Inserts land at wr_ptr in ring order, a tick ages every live slot, and
// expired slots are drained one per cycle through a registered valid/ready
// output. The scan for the next expired slot starts at rd_ptr so slots are
// served round-robin. Live slots can be cancelled by index before they expire.
module pkt_timer_ring #(
    parameter int INFO_W = 262,
    parameter int DEPTH  = 16,
    parameter int TM_W   = 6,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INFO_W-1:0] in_info,
    input  logic [TM_W-1:0]   in_tm,
    output logic [IDX_W-1:0]  in_idx,
    input  logic              cancel_valid,
    input  logic [IDX_W-1:0]  cancel_idx,
    output logic              cancel_hit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INFO_W-1:0] out_info,
    output logic [IDX_W-1:0]  out_idx,
    output logic [IDX_W:0]    occupancy
);

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W:0]   OCC_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]   OCC_ZERO = (IDX_W+1)'(0);
    localparam logic [TM_W-1:0]  TM_ONE   = TM_W'(1);
    localparam logic [TM_W-1:0]  TM_ZERO  = TM_W'(0);

    // Slot state
    logic [DEPTH-1:0]  used_q, used_d;
    logic [TM_W-1:0]   tm_q [DEPTH];
    logic [TM_W-1:0]   tm_d [DEPTH];
    logic [INFO_W-1:0] info_mem_q [DEPTH];

    // Ring pointers, output register and status
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [INFO_W-1:0] out_info_q, out_info_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              cancel_hit_q, cancel_hit_d;
    logic [IDX_W:0]    occupancy_q, occupancy_d;

    // Per-cycle decisions
    logic [DEPTH-1:0]  expired_s;
    logic              sel_found_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic [IDX_W-1:0]  cand_s;
    logic              load_s;
    logic              ins_s;
    logic              cancel_free_s;

    // in_ready only looks at registered state, never at same-cycle frees.
    assign in_ready   = ~used_q[wr_ptr_q];
    assign in_idx     = wr_ptr_q;
    assign cancel_hit = cancel_hit_q;
    assign out_valid  = out_valid_q;
    assign out_info   = out_info_q;
    assign out_idx    = out_idx_q;
    assign occupancy  = occupancy_q;

    // A slot is expired when it is live and its timer has reached zero.
    always_comb begin
        expired_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            expired_s[i] = used_q[i] && (tm_q[i] == TM_ZERO);
        end
    end

    // Pick the first expired slot scanning upward from rd_ptr with wrap.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = rd_ptr_q;
        cand_s      = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            cand_s = rd_ptr_q + IDX_W'(i);
            if (!sel_found_s && expired_s[cand_s]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s;
            end else begin
                sel_idx_s   = sel_idx_s;
            end
        end
    end

    // Handshake decisions; a load wins over a cancel aimed at the same slot.
    always_comb begin
        load_s        = sel_found_s && (!out_valid_q || out_ready);
        ins_s         = in_valid && !used_q[wr_ptr_q];
        cancel_free_s = cancel_valid && used_q[cancel_idx]
                        && !(load_s && (sel_idx_s == cancel_idx));
    end

    // Next slot flags and timers; a slot being written takes in_tm unaged.
    always_comb begin
        used_d = used_q;
        for (int i = 0; i < DEPTH; i++) begin
            tm_d[i] = tm_q[i];
            if (ins_s && (wr_ptr_q == IDX_W'(i))) begin
                used_d[i] = 1'b1;
                tm_d[i]   = in_tm;
            end else if ((load_s && (sel_idx_s == IDX_W'(i)))
                         || (cancel_free_s && (cancel_idx == IDX_W'(i)))) begin
                used_d[i] = 1'b0;
                tm_d[i]   = tm_q[i];
            end else if (tick && used_q[i] && (tm_q[i] != TM_ZERO)) begin
                used_d[i] = used_q[i];
                tm_d[i]   = tm_q[i] - TM_ONE;
            end else begin
                used_d[i] = used_q[i];
                tm_d[i]   = tm_q[i];
            end
        end
    end

    // Next pointers, occupancy, cancel pulse and output register contents.
    always_comb begin
        wr_ptr_d     = ins_s  ? (wr_ptr_q + IDX_ONE)  : wr_ptr_q;
        rd_ptr_d     = load_s ? (sel_idx_s + IDX_ONE) : rd_ptr_q;
        occupancy_d  = occupancy_q
                       + (ins_s         ? OCC_ONE : OCC_ZERO)
                       - (load_s        ? OCC_ONE : OCC_ZERO)
                       - (cancel_free_s ? OCC_ONE : OCC_ZERO);
        cancel_hit_d = cancel_free_s;
        out_valid_d  = out_valid_q;
        out_info_d   = out_info_q;
        out_idx_d    = out_idx_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            out_info_d  = info_mem_q[sel_idx_s];
            out_idx_d   = sel_idx_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Record payload storage; contents are meaningless while a slot is free.
    always_ff @(posedge clk) begin
        if (ins_s) begin
            info_mem_q[wr_ptr_q] <= in_info;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            used_q       <= '0;
            wr_ptr_q     <= IDX_ZERO;
            rd_ptr_q     <= IDX_ZERO;
            out_valid_q  <= 1'b0;
            out_info_q   <= '0;
            out_idx_q    <= IDX_ZERO;
            cancel_hit_q <= 1'b0;
            occupancy_q  <= OCC_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                tm_q[i] <= TM_ZERO;
            end
        end else begin
            used_q       <= used_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_valid_q  <= out_valid_d;
            out_info_q   <= out_info_d;
            out_idx_q    <= out_idx_d;
            cancel_hit_q <= cancel_hit_d;
            occupancy_q  <= occupancy_d;
            for (int i = 0; i < DEPTH; i++) begin
                tm_q[i] <= tm_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pkt_timer_ring.sv
// Testbench for pkt_timer_ring: scenario tasks with inline checks plus a
// scoreboard of expected emitted records, compared at each output handshake.
module tb_pkt_timer_ring;

    localparam int INFO_W = 262;
    localparam int DEPTH  = 16;
    localparam int TM_W   = 6;
    localparam int IDX_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              tick;
    logic              in_valid;
    logic              in_ready;
    logic [INFO_W-1:0] in_info;
    logic [TM_W-1:0]   in_tm;
    logic [IDX_W-1:0]  in_idx;
    logic              cancel_valid;
    logic [IDX_W-1:0]  cancel_idx;
    logic              cancel_hit;
    logic              out_valid;
    logic              out_ready;
    logic [INFO_W-1:0] out_info;
    logic [IDX_W-1:0]  out_idx;
    logic [IDX_W:0]    occupancy;

    typedef struct {
        logic [INFO_W-1:0] info;
        logic [IDX_W-1:0]  idx;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    logic [INFO_W-1:0] slot_info [DEPTH];
    int                checks = 0;
    int                errors = 0;
    int                n_cyc;

    pkt_timer_ring #(
        .INFO_W(INFO_W), .DEPTH(DEPTH), .TM_W(TM_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .in_valid(in_valid), .in_ready(in_ready), .in_info(in_info),
        .in_tm(in_tm), .in_idx(in_idx),
        .cancel_valid(cancel_valid), .cancel_idx(cancel_idx), .cancel_hit(cancel_hit),
        .out_valid(out_valid), .out_ready(out_ready), .out_info(out_info),
        .out_idx(out_idx), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INFO_W-1:0] rand_info();
        logic [287:0] w;
        for (int k = 0; k < 9; k++) w[k*32 +: 32] = $urandom;
        return w[INFO_W-1:0];
    endfunction

    // Advance one clock; at the falling edge, any handshake about to happen
    // is matched against the head of the scoreboard.
    task automatic cyc();
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: emitted idx %0d, expected nothing", out_idx);
            end else begin
                mon_e = sb.pop_front();
                if (out_idx !== mon_e.idx || out_info !== mon_e.info) begin
                    errors++;
                    $display("FAIL sb_record: got idx %0d info %h, expected idx %0d info %h",
                             out_idx, out_info, mon_e.idx, mon_e.info);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_insert(input int idx, input int tm);
        slot_info[idx] = rand_info();
        in_valid = 1'b1;
        in_info  = slot_info[idx];
        in_tm    = TM_W'(tm);
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.info = slot_info[idx];
        e.idx  = IDX_W'(idx);
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        tick = 1'b0; in_valid = 1'b0; in_info = '0; in_tm = 6'd0;
        cancel_valid = 1'b0; cancel_idx = 4'd0; out_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc(); cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++; if (in_ready !== 1'b1 || in_idx !== 4'd0) begin errors++; $display("FAIL reset_in: got ready %0b idx %0d expected 1 0", in_ready, in_idx); end
        checks++; if (cancel_hit !== 1'b0 || out_idx !== 4'd0 || out_info !== '0) begin errors++; $display("FAIL reset_out_regs: got hit %0b idx %0d info %h expected zeros", cancel_hit, out_idx, out_info); end
        rst_n = 1'b1;
    endtask

    // Three inserts, tm=2, ticking every cycle: emitted 0,1,2 back to back.
    task automatic test_basic();
        do_reset();
        tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_insert(i, 2);
            push_exp(i);
            checks++; if (in_idx !== IDX_W'(i) || in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_idx: got %0d ready %0b expected %0d 1", in_idx, in_ready, i); end
            cyc();
        end
        in_valid = 1'b0;
        checks++; if (occupancy !== 5'd3 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_occ3: got occ %0d valid %0b expected 3 0", occupancy, out_valid); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (out_valid !== 1'b1 || out_idx !== IDX_W'(k) || occupancy !== 5'(2 - k)) begin
                errors++; $display("FAIL basic_emit: got valid %0b idx %0d occ %0d expected 1 %0d %0d", out_valid, out_idx, occupancy, k, 2 - k);
            end
        end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got valid %0b expected 0", out_valid); end
        tick = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_sb_left: got %0d pending expected 0", sb.size()); end
    endtask

    // Fill all slots, check full behaviour, then age and drain at full rate.
    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %0b expected 1", i, in_ready); end
            drive_insert(i, 5);
            push_exp(i);
            cyc();
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || occupancy !== 5'd16 || out_valid !== 1'b0) begin
            errors++; $display("FAIL full_state: got ready %0b occ %0d valid %0b expected 0 16 0", in_ready, occupancy, out_valid);
        end
        in_valid = 1'b1; in_info = rand_info(); in_tm = 6'd5;
        cyc();
        in_valid = 1'b0;
        checks++; if (occupancy !== 5'd16 || in_idx !== 4'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL full_17th: got occ %0d idx %0d valid %0b expected 16 0 0", occupancy, in_idx, out_valid);
        end
        tick = 1'b1;
        repeat (5) cyc();
        tick = 1'b0;
        n_cyc = 0;
        while (n_cyc < 64 && (sb.size() != 0 || out_valid)) begin cyc(); n_cyc++; end
        checks++; if (sb.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL full_drain_timeout: got %0d pending expected 0", sb.size()); end
        checks++; if (n_cyc != 17) begin errors++; $display("FAIL full_throughput: got %0d cycles expected 17", n_cyc); end
        checks++; if (occupancy !== 5'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL full_empty: got occ %0d ready %0b expected 0 1", occupancy, in_ready); end
    endtask

    // tm=0 insert with a stalled consumer: output holds, slot 0 is free again.
    task automatic test_hold();
        do_reset();
        out_ready = 1'b0;
        drive_insert(0, 0);
        push_exp(0);
        cyc();
        checks++; if (out_valid !== 1'b0 || occupancy !== 5'd1) begin errors++; $display("FAIL hold_latency: got valid %0b occ %0d expected 0 1", out_valid, occupancy); end
        for (int j = 1; j < DEPTH; j++) begin
            drive_insert(j, 20);
            cyc();
            checks++; if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_info !== slot_info[0]) begin
                errors++; $display("FAIL hold_stable_%0d: got valid %0b idx %0d expected 1 0", j, out_valid, out_idx);
            end
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1 || in_idx !== 4'd0 || occupancy !== 5'd15) begin
            errors++; $display("FAIL hold_wrap: got ready %0b idx %0d occ %0d expected 1 0 15", in_ready, in_idx, occupancy);
        end
        drive_insert(0, 0);
        push_exp(0);
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        n_cyc = 0;
        while (n_cyc < 64 && (sb.size() != 0 || out_valid)) begin cyc(); n_cyc++; end
        checks++; if (sb.size() != 0 || occupancy !== 5'd15) begin errors++; $display("FAIL hold_reinsert: got %0d pending occ %0d expected 0 15", sb.size(), occupancy); end
    endtask

    // Round-robin: slots 3 and 9 expire together with rd_ptr at 5.
    task automatic test_round_robin();
        int tmv;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tmv = (i == 4) ? 0 : ((i == 3 || i == 9) ? 3 : ((i == 2 || i == 5) ? 5 : 40));
            drive_insert(i, tmv);
            if (i == 4) push_exp(4);
            cyc();
        end
        in_valid = 1'b0;
        checks++; if (occupancy !== 5'd9 || sb.size() != 0) begin errors++; $display("FAIL rr_setup: got occ %0d pending %0d expected 9 0", occupancy, sb.size()); end
        tick = 1'b1;
        push_exp(9);
        push_exp(3);
        repeat (3) cyc();
        tick = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b1 || out_idx !== 4'd9) begin errors++; $display("FAIL rr_first: got valid %0b idx %0d expected 1 9", out_valid, out_idx); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_idx !== 4'd3 || occupancy !== 5'd7) begin errors++; $display("FAIL rr_second: got idx %0d occ %0d expected 3 7", out_idx, occupancy); end
        tick = 1'b1;
        push_exp(5);
        push_exp(2);
        repeat (2) cyc();
        tick = 1'b0;
        n_cyc = 0;
        while (n_cyc < 64 && (sb.size() != 0 || out_valid)) begin cyc(); n_cyc++; end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rr_rdptr_order: got %0d pending expected 0", sb.size()); end
    endtask

    // Cancel a live slot (with a concurrent insert), then cancel it again.
    task automatic test_cancel();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_insert(i, (i == 4) ? 7 : 30);
            cyc();
        end
        drive_insert(5, 30);
        cancel_valid = 1'b1; cancel_idx = 4'd4;
        cyc();
        in_valid = 1'b0;
        checks++; if (cancel_hit !== 1'b1 || occupancy !== 5'd5 || in_idx !== 4'd6) begin
            errors++; $display("FAIL cancel_hit: got hit %0b occ %0d idx %0d expected 1 5 6", cancel_hit, occupancy, in_idx);
        end
        cyc();
        cancel_valid = 1'b0;
        checks++; if (cancel_hit !== 1'b0 || occupancy !== 5'd5) begin errors++; $display("FAIL cancel_again: got hit %0b occ %0d expected 0 5", cancel_hit, occupancy); end
        tick = 1'b1;
        repeat (10) cyc();
        tick = 1'b0;
        checks++; if (out_valid !== 1'b0 || occupancy !== 5'd5) begin errors++; $display("FAIL cancel_no_emit: got valid %0b occ %0d expected 0 5", out_valid, occupancy); end
    endtask

    // Load beats cancel on the same slot; then reset mid-operation.
    task automatic test_cancel_load_reset();
        do_reset();
        out_ready = 1'b0;
        drive_insert(0, 30); cyc();
        drive_insert(1, 30); cyc();
        drive_insert(2, 0);  cyc();
        in_valid = 1'b0;
        cancel_valid = 1'b1; cancel_idx = 4'd2;
        cyc();
        checks++; if (out_valid !== 1'b1 || out_idx !== 4'd2 || out_info !== slot_info[2] || cancel_hit !== 1'b0 || occupancy !== 5'd2) begin
            errors++; $display("FAIL load_beats_cancel: got valid %0b idx %0d hit %0b occ %0d expected 1 2 0 2", out_valid, out_idx, cancel_hit, occupancy);
        end
        cyc();
        cancel_valid = 1'b0;
        checks++; if (cancel_hit !== 1'b0 || out_valid !== 1'b1 || out_info !== slot_info[2]) begin
            errors++; $display("FAIL cancel_outreg: got hit %0b valid %0b expected 0 1", cancel_hit, out_valid);
        end
        for (int i = 3; i < 6; i++) begin drive_insert(i, 30); cyc(); end
        in_valid = 1'b0;
        checks++; if (occupancy !== 5'd5) begin errors++; $display("FAIL pre_reset_occ: got %0d expected 5", occupancy); end
        rst_n = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0 || occupancy !== 5'd0 || in_ready !== 1'b1 || in_idx !== 4'd0) begin
            errors++; $display("FAIL midreset_state: got valid %0b occ %0d ready %0b idx %0d expected 0 0 1 0", out_valid, occupancy, in_ready, in_idx);
        end
        checks++; if (out_info !== '0 || out_idx !== 4'd0 || cancel_hit !== 1'b0) begin errors++; $display("FAIL midreset_outreg: got idx %0d hit %0b info %h expected zeros", out_idx, cancel_hit, out_info); end
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick = 1'b1;
        repeat (40) cyc();
        tick = 1'b0;
        checks++; if (out_valid !== 1'b0 || occupancy !== 5'd0) begin errors++; $display("FAIL midreset_discard: got valid %0b occ %0d expected 0 0", out_valid, occupancy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_hold();
        test_round_robin();
        test_cancel();
        test_cancel_load_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
